multicycle_ctrl: RTL

//  Parametrised multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
//  req/ack handshakes to instruction and data memory, multi-cycle MULT, JAL/BNE support,
//  a watchdog timeout, an illegal-opcode trap mode and optional perf counters.

---
 rtl/multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction
// and data memory, a multi-cycle MULT/MULTU, a memory watchdog and an
// optional illegal-opcode trap. All outputs are registered Moore outputs.
// Optional feature: define CTRL_PERF_EN to build the cycle/instret counters;
// without it both counter outputs are tied to zero.
//
// state  | meaning
// RESET  | first cycle out of reset, always moves to FETCH
// FETCH  | imem_req high, waiting for imem_ack; ir latched on ack
// DECODE | classify ir by opcode/funct
// EXEC   | ALU/branch/address cycle; MULT stays MUL_CYCLES cycles
// MEM    | dmem_req high, waiting for dmem_ack
// WB     | one writeback cycle, wb_sel selects the result source
// ERROR  | sticky trap (watchdog or illegal opcode), left only by reset
module multicycle_ctrl #(
    parameter int MUL_CYCLES   = 4,
    parameter int MEM_TIMEOUT  = 15,
    parameter int ILLEGAL_TRAP = 0,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [31:0]       ir,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              execute_en,
    output logic              memory_en,
    output logic              writeback_en,
    output logic [1:0]        wb_sel,
    output logic              hilo_we,
    output logic              retire,
    output logic              err,
    output logic [2:0]        state_o,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;

    // MULT down-counter holds MUL_CYCLES-1 .. 0; watchdog counts 0 .. MEM_TIMEOUT-1
    localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [MC_W-1:0]   mul_q, mul_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              imem_req_q, dmem_req_q, dmem_we_q;
    logic              fetch_en_q, decode_en_q, execute_en_q, memory_en_q, writeback_en_q;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic              hilo_we_q, hilo_we_d;
    logic              retire_q, retire_d;
    logic              err_q;

    logic [5:0]        op_q, fn_q, op_d;
    logic              is_mult;
    logic              timeout_hit;

    assign op_q        = ir_q[31:26];
    assign fn_q        = ir_q[5:0];
    assign op_d        = ir_d[31:26];
    assign is_mult     = (op_q == OP_R) && ((fn_q == FN_MULT) || (fn_q == FN_MULTU));
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wd_q == WD_LAST);

    // next-state, instruction latch, MULT/watchdog counters and next registered outputs
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        mul_d    = mul_q;
        wd_d     = '0;
        retire_d = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d = imem_rdata;
                    if (imem_rdata == 32'd0) begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end else begin
                        state_d = S_DECODE;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (MEM_TIMEOUT != 0) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DECODE: begin
                case (op_q)
                    OP_J: begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end
                    OP_JAL: state_d = S_WB;
                    OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
                    OP_R: begin
                        if (fn_q == 6'd0) begin
                            state_d  = S_FETCH;
                            retire_d = 1'b1;
                        end else begin
                            state_d = S_EXEC;
                            mul_d   = MUL_LOAD;
                        end
                    end
                    default: begin
                        if (ILLEGAL_TRAP != 0) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d  = S_FETCH;
                            retire_d = 1'b1;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                if (is_mult) begin
                    if (mul_q == '0) begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end else begin
                        mul_d = mul_q - 1'b1;
                    end
                end else if ((op_q == OP_R) || (op_q == OP_ADDI)) begin
                    state_d = S_WB;
                end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op_q == OP_SW) begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (MEM_TIMEOUT != 0) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        wb_sel_d = 2'd0;
        if (state_d == S_WB) begin
            if (op_d == OP_JAL)     wb_sel_d = 2'd2;
            else if (op_d == OP_LW) wb_sel_d = 2'd1;
        end
        hilo_we_d = (state_d == S_EXEC) && is_mult && (mul_d == '0);
    end

    // FSM state, instruction register, counters and registered Moore outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_RESET;
            ir_q           <= '0;
            mul_q          <= '0;
            wd_q           <= '0;
            imem_req_q     <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            fetch_en_q     <= 1'b0;
            decode_en_q    <= 1'b0;
            execute_en_q   <= 1'b0;
            memory_en_q    <= 1'b0;
            writeback_en_q <= 1'b0;
            wb_sel_q       <= 2'd0;
            hilo_we_q      <= 1'b0;
            retire_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            mul_q          <= mul_d;
            wd_q           <= wd_d;
            imem_req_q     <= (state_d == S_FETCH);
            dmem_req_q     <= (state_d == S_MEM);
            dmem_we_q      <= (state_d == S_MEM) && (op_d == OP_SW);
            fetch_en_q     <= (state_d == S_FETCH);
            decode_en_q    <= (state_d == S_DECODE);
            execute_en_q   <= (state_d == S_EXEC);
            memory_en_q    <= (state_d == S_MEM);
            writeback_en_q <= (state_d == S_WB);
            wb_sel_q       <= wb_sel_d;
            hilo_we_q      <= hilo_we_d;
            retire_q       <= retire_d;
            err_q          <= (state_d == S_ERROR);
        end
    end

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_q, cycle_d;
    logic [PERF_W-1:0] instret_q, instret_d;

    // counters advance alongside the FSM and freeze once it has trapped
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (state_q != S_ERROR) begin
            cycle_d = cycle_q + 1'b1;
            if (retire_d) instret_d = instret_q + 1'b1;
        end
    end

    // perf counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

    assign imem_req     = imem_req_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign ir           = ir_q;
    assign fetch_en     = fetch_en_q;
    assign decode_en    = decode_en_q;
    assign execute_en   = execute_en_q;
    assign memory_en    = memory_en_q;
    assign writeback_en = writeback_en_q;
    assign wb_sel       = wb_sel_q;
    assign hilo_we      = hilo_we_q;
    assign retire       = retire_q;
    assign err          = err_q;
    assign state_o      = state_q;

endmodule
